// File: rtl/seq_detect_param.sv
// Serial pattern detector with selectable overlap, a sync clear and a Moore detect pulse.
// The saturating det_cnt counter exists only when SEQ_DETECT_CNT_EN is defined; otherwise det_cnt is tied to 0.
module seq_detect_param #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int              CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             clr,
    output logic             out,
    output logic [CNT_W-1:0] det_cnt
);

    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    generate
        if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
            $fatal(1, "seq_detect_param: PAT_W=%0d outside 2..16", PAT_W);
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $fatal(1, "seq_detect_param: CNT_W=%0d must be at least 1", CNT_W);
        end
    endgenerate

    logic [PAT_W-1:0] hist_q, hist_d, shifted;
    logic [FW-1:0]    fill_q, fill_d, fill_inc;
    logic             out_q;
    logic             match;

    always_comb begin
        hist_d   = hist_q;
        fill_d   = fill_q;
        match    = 1'b0;
        shifted  = {hist_q[PAT_W-2:0], in};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        // clr outranks a bit arriving on the same edge; that bit is dropped
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            hist_d = shifted;
            fill_d = fill_inc;
            if (fill_inc == FULL && shifted == PATTERN) begin
                match = 1'b1;
                if (!overlap_en)
                    fill_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
            out_q  <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            out_q  <= match;
        end
    end

    assign out = out_q;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (clr)
            cnt_q <= '0;
        else if (match && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign det_cnt = cnt_q;
`else
    assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: table vectors, directed corner sequences and random stimulus
// checked against a queue-based reference model (CNT_W=8 and CNT_W=2 instances side by side).
module tb_seq_detect_param;

    localparam logic [3:0] PAT = 4'b1101;
`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       in_valid = 1'b0;
    logic       overlap_en = 1'b0;
    logic       clr = 1'b0;
    logic       out_a, out_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    seq_detect_param #(.PAT_W(4), .PATTERN(PAT), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap_en(overlap_en),
        .clr(clr), .out(out_a), .det_cnt(cnt_a));

    seq_detect_param #(.PAT_W(4), .PATTERN(PAT), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in(din), .in_valid(in_valid), .overlap_en(overlap_en),
        .clr(clr), .out(out_b), .det_cnt(cnt_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the last accepted bits since reset/clear/non-overlapping match
    bit   hq[$];
    int   nmatch  = 0;
    bit   exp_out = 1'b0;
    logic [3:0] pat_v = PAT;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        hq.delete();
        nmatch  = 0;
        exp_out = 1'b0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit ov, input bit c);
        bit m;
        if (c) begin
            model_reset();
        end else if (v) begin
            hq.push_back(b);
            if (hq.size() > 4) void'(hq.pop_front());
            m = 1'b0;
            if (hq.size() == 4) begin
                m = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (hq[i] != pat_v[3-i]) m = 1'b0;
            end
            exp_out = m;
            if (m) begin
                nmatch++;
                if (!ov) hq.delete();
            end
        end else begin
            exp_out = 1'b0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out8"}, int'(out_a), int'(exp_out));
        check({tag, ".out2"}, int'(out_b), int'(exp_out));
        check({tag, ".cnt8"}, int'(cnt_a), CNT_EN ? sat(nmatch, 255) : 0);
        check({tag, ".cnt2"}, int'(cnt_b), CNT_EN ? sat(nmatch, 3) : 0);
    endtask

    task automatic step(input string tag, input bit v, input bit b, input bit ov, input bit c);
        din = b; in_valid = v; overlap_en = ov; clr = c;
        @(posedge clk);
        model_edge(v, b, ov, c);
        #1;
        check_model(tag);
    endtask

    task automatic bits(input string tag, input logic [15:0] seq, input int n, input bit ov);
        logic [15:0] s;
        s = seq;
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, s[i], ov, 1'b0);
    endtask

    typedef struct {
        bit v;
        bit b;
        bit ov;
        bit c;
        bit eo;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // clear + stream 1101101 non-overlapping, then clear + same stream overlapping
        tbl.push_back('{0,0,0,1,0});
        tbl.push_back('{1,1,0,0,0}); tbl.push_back('{1,1,0,0,0});
        tbl.push_back('{1,0,0,0,0}); tbl.push_back('{1,1,0,0,1});
        tbl.push_back('{1,1,0,0,0}); tbl.push_back('{1,0,0,0,0});
        tbl.push_back('{1,1,0,0,0});
        tbl.push_back('{0,0,1,1,0});
        tbl.push_back('{1,1,1,0,0}); tbl.push_back('{1,1,1,0,0});
        tbl.push_back('{1,0,1,0,0}); tbl.push_back('{1,1,1,0,1});
        tbl.push_back('{1,1,1,0,0}); tbl.push_back('{1,0,1,0,0});
        tbl.push_back('{1,1,1,0,1});

        model_reset();
        #2;
        check("reset.out8", int'(out_a), 0);
        check("reset.cnt8", int'(cnt_a), 0);
        check("reset.cnt2", int'(cnt_b), 0);
        #10 rst = 1'b1;

        foreach (tbl[k]) begin
            step("table", tbl[k].v, tbl[k].b, tbl[k].ov, tbl[k].c);
            check("table.out_const", int'(out_a), int'(tbl[k].eo));
            if (k == 7)  check("table.cnt_nonovl", int'(cnt_a), CNT_EN ? 1 : 0);
            if (k == 15) check("table.cnt_ovl", int'(cnt_a), CNT_EN ? 2 : 0);
        end

        // 110 accepted, then async reset between edges
        step("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rst", 1'b1, 1'b1, 1'b0, 1'b0);
        step("rst", 1'b1, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check("rst.async_out", int'(out_a), 0);
        check("rst.async_cnt8", int'(cnt_a), 0);
        check("rst.async_cnt2", int'(cnt_b), 0);
        #1 rst = 1'b1;
        step("rst.after1", 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst.no_detect", int'(out_a), 0);
        bits("rst.full", 16'b1101, 4, 1'b0);
        check("rst.pulse", int'(out_a), 1);

        // valid bits separated by idle cycles carrying in=0
        step("gap.clr", 1'b0, 1'b0, 1'b0, 1'b1);
        step("gap", 1'b1, 1'b1, 1'b0, 1'b0);
        step("gap", 1'b0, 1'b0, 1'b0, 1'b0);
        step("gap", 1'b1, 1'b1, 1'b0, 1'b0);
        step("gap", 1'b0, 1'b0, 1'b0, 1'b0);
        step("gap", 1'b0, 1'b0, 1'b0, 1'b0);
        step("gap", 1'b1, 1'b0, 1'b0, 1'b0);
        step("gap", 1'b0, 1'b0, 1'b0, 1'b0);
        step("gap", 1'b1, 1'b1, 1'b0, 1'b0);
        check("gap.pulse", int'(out_a), 1);
        step("gap.after", 1'b0, 1'b0, 1'b0, 1'b0);
        check("gap.one_cycle", int'(out_a), 0);

        // clr on the edge of the final bit
        bits("clr", 16'b110, 3, 1'b0);
        step("clr.final", 1'b1, 1'b1, 1'b0, 1'b1);
        check("clr.no_pulse", int'(out_a), 0);
        check("clr.cnt", int'(cnt_a), 0);
        bits("clr.next", 16'b1101, 4, 1'b0);
        check("clr.next_pulse", int'(out_a), 1);

        // five overlapping matches saturate the 2-bit counter at 3
        step("sat.clr", 1'b0, 1'b0, 1'b1, 1'b1);
        bits("sat", 16'b1101101101101101, 16, 1'b1);
        check("sat.cnt2", int'(cnt_b), CNT_EN ? 3 : 0);
        check("sat.cnt8", int'(cnt_a), CNT_EN ? 5 : 0);

        // random traffic, overlap toggled freely between bits
        for (int r = 0; r < 3000; r++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
